// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter: one input bit per clock,
// start/busy/done handshake, registered result with overflow flag and leading-zero mask.
module bin2bcd_seq #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [WIDTH-1:0]      bin_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [4*DIGITS-1:0]   bcd_o,
    output logic                  ovf_o,
    output logic [DIGITS-1:0]     dig_en_o,
    output logic                  state_o
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int ACC_W = 4 * DIGITS;

    typedef enum logic {S_IDLE = 1'b0, S_CONV = 1'b1} state_t;

    state_t              state_q;
    logic [WIDTH-1:0]    sr_q;
    logic [ACC_W-1:0]    acc_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                ov_q;
    logic                busy_q;
    logic                done_q;
    logic [ACC_W-1:0]    bcd_q;
    logic                ovf_q;
    logic [DIGITS-1:0]   dig_en_q;

    logic [ACC_W-1:0]    acc_adj;
    logic [ACC_W-1:0]    acc_d;
    logic [WIDTH-1:0]    sr_d;
    logic                ov_d;
    logic                last_d;
    logic                any_nz;
    logic [DIGITS-1:0]   dig_en_d;

    // Handshake: start_i is accepted on an edge only while IDLE (busy_o=0); busy_o
    // stays high for WIDTH cycles, then done_o pulses for one cycle with busy_o low.
    always_comb begin
        acc_adj = acc_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) begin
                acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
            end
        end
        acc_d  = {acc_adj[ACC_W-2:0], sr_q[WIDTH-1]};
        sr_d   = sr_q << 1;
        ov_d   = ov_q | acc_adj[ACC_W-1];
        last_d = (cnt_q == CNT_W'(WIDTH - 1));

        // Digit i is shown if it or any more significant digit is nonzero.
        any_nz   = 1'b0;
        dig_en_d = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            any_nz      = any_nz | (|acc_d[4*i +: 4]);
            dig_en_d[i] = any_nz;
        end
        dig_en_d[0] = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            sr_q     <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            ov_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            bcd_q    <= '0;
            ovf_q    <= 1'b0;
            dig_en_q <= DIGITS'(1);
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        sr_q    <= bin_i;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        ov_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_CONV;
                    end
                end
                S_CONV: begin
                    acc_q <= acc_d;
                    sr_q  <= sr_d;
                    ov_q  <= ov_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (last_d) begin
                        bcd_q    <= acc_d;
                        ovf_q    <= ov_d;
                        dig_en_q <= dig_en_d;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign bcd_o    = bcd_q;
    assign ovf_o    = ovf_q;
    assign dig_en_o = dig_en_q;
    assign state_o  = (state_q == S_CONV);

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed and randomized checks of bin2bcd_seq against an arithmetic decimal model,
// using a 16-bit/5-digit instance and an 8-bit/2-digit instance.
module tb_bin2bcd_seq;
    logic clk = 1'b0;
    logic rst = 1'b0;

    logic        start16 = 1'b0;
    logic [15:0] bin16   = '0;
    logic        busy16, done16, ovf16, st16;
    logic [19:0] bcd16;
    logic [4:0]  en16;

    logic        start8 = 1'b0;
    logic [7:0]  bin8   = '0;
    logic        busy8, done8, ovf8, st8;
    logic [7:0]  bcd8;
    logic [1:0]  en8;

    int checks   = 0;
    int failures = 0;
    logic [31:0] last_exp16 = '0;

    bin2bcd_seq #(.WIDTH(16), .DIGITS(5)) u16 (
        .clk_i(clk), .rst_i(rst), .start_i(start16), .bin_i(bin16),
        .busy_o(busy16), .done_o(done16), .bcd_o(bcd16), .ovf_o(ovf16),
        .dig_en_o(en16), .state_o(st16)
    );

    bin2bcd_seq #(.WIDTH(8), .DIGITS(2)) u8 (
        .clk_i(clk), .rst_i(rst), .start_i(start8), .bin_i(bin8),
        .busy_o(busy8), .done_o(done8), .bcd_o(bcd8), .ovf_o(ovf8),
        .dig_en_o(en8), .state_o(st8)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Decimal model: result is v mod 10^d, digit-packed; mask from digit values.
    task automatic model(input int v, input int d, output logic [31:0] bcd,
                         output logic [31:0] ovf, output logic [31:0] en);
        int p, r, dig;
        logic any;
        logic [31:0] digs [8];
        p = 1;
        for (int i = 0; i < d; i++) p = p * 10;
        ovf = (v >= p) ? 32'd1 : 32'd0;
        r   = v % p;
        bcd = '0;
        for (int i = 0; i < d; i++) begin
            dig     = r % 10;
            digs[i] = 32'(dig);
            bcd     = bcd | (32'(dig) << (4 * i));
            r       = r / 10;
        end
        en  = 32'd1;
        any = 1'b0;
        for (int i = d - 1; i >= 1; i--) begin
            any = any | (digs[i] != 0);
            if (any) en = en | (32'd1 << i);
        end
    endtask

    // Called right after an accepting edge; steps until done16 or a 40-edge budget.
    task automatic wait_done16(output int edges, output int busyc, output int overlap,
                               output int held_bad);
        edges = 0; busyc = 0; overlap = 0; held_bad = 0;
        while (1) begin
            if (busy16 && done16) overlap++;
            if (done16) break;
            if (busy16) busyc++;
            if (32'(bcd16) !== last_exp16) held_bad++;
            if (edges >= 40) break;
            step();
            edges++;
        end
    endtask

    task automatic check_result16(input string tag, input int v);
        logic [31:0] eb, eo, ee;
        model(v, 5, eb, eo, ee);
        chk({tag, "_bcd"}, 32'(bcd16), eb);
        chk({tag, "_ovf"}, 32'(ovf16), eo);
        chk({tag, "_en"},  32'(en16),  ee);
        last_exp16 = eb;
    endtask

    task automatic conv16(input string tag, input logic [15:0] v);
        int edges, busyc, overlap, held_bad;
        start16 = 1'b1;
        bin16   = v;
        step();
        start16 = 1'b0;
        bin16   = 16'($urandom);
        wait_done16(edges, busyc, overlap, held_bad);
        chk({tag, "_lat"},  32'(edges), 32'd16);
        chk({tag, "_busy"}, 32'(busyc), 32'd16);
        chk({tag, "_ovlp"}, 32'(overlap), 32'd0);
        chk({tag, "_held"}, 32'(held_bad), 32'd0);
        check_result16(tag, int'(v));
        step();
        chk({tag, "_done1"}, 32'(done16), 32'd0);
    endtask

    task automatic conv8(input string tag, input logic [7:0] v);
        int edges;
        logic [31:0] eb, eo, ee;
        start8 = 1'b1;
        bin8   = v;
        step();
        start8 = 1'b0;
        bin8   = 8'($urandom);
        edges  = 0;
        while (!done8 && edges < 30) begin
            step();
            edges++;
        end
        chk({tag, "_lat"}, 32'(edges), 32'd8);
        model(int'(v), 2, eb, eo, ee);
        chk({tag, "_bcd"}, 32'(bcd8), eb);
        chk({tag, "_ovf"}, 32'(ovf8), eo);
        chk({tag, "_en"},  32'(en8),  ee);
        step();
    endtask

    initial begin
        int edges, busyc, overlap, held_bad, seen;
        logic [15:0] r16;

        // Reset state
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        chk("rst_busy", 32'(busy16), 32'd0);
        chk("rst_done", 32'(done16), 32'd0);
        chk("rst_bcd",  32'(bcd16),  32'd0);
        chk("rst_ovf",  32'(ovf16),  32'd0);
        chk("rst_en",   32'(en16),   32'd1);
        chk("rst_st",   32'(st16),   32'd0);
        chk("rst8_en",  32'(en8),    32'd1);

        // Basic directed conversions
        conv16("zero", 16'd0);
        conv16("d1234", 16'd1234);
        conv16("d65535", 16'd65535);

        // Continuous conversion with start held high
        start16 = 1'b1;
        bin16   = 16'd9;
        step();
        chk("cont_state", 32'(st16), 32'd1);
        bin16 = 16'd10;
        wait_done16(edges, busyc, overlap, held_bad);
        chk("cont9_lat", 32'(edges), 32'd16);
        check_result16("cont9", 9);
        step();
        chk("cont_done1", 32'(done16), 32'd0);
        bin16 = 16'd99;
        wait_done16(edges, busyc, overlap, held_bad);
        chk("cont10_period", 32'(edges + 1), 32'd17);
        chk("cont10_held", 32'(held_bad), 32'd0);
        check_result16("cont10", 10);
        step();
        start16 = 1'b0;
        bin16   = 16'd7;
        wait_done16(edges, busyc, overlap, held_bad);
        chk("cont99_period", 32'(edges + 1), 32'd17);
        chk("cont99_held", 32'(held_bad), 32'd0);
        check_result16("cont99", 99);
        step();

        // start mid-conversion is ignored
        start16 = 1'b1;
        bin16   = 16'd4000;
        step();
        start16 = 1'b0;
        step(); step(); step(); step();
        start16 = 1'b1;
        bin16   = 16'd1111;
        step();
        start16 = 1'b0;
        wait_done16(edges, busyc, overlap, held_bad);
        chk("mid_lat", 32'(edges + 5), 32'd16);
        check_result16("mid", 4000);
        step();
        chk("mid_nostart", 32'(busy16), 32'd0);

        // Narrow instance: overflow and boundaries
        conv8("n255", 8'd255);
        conv8("n99", 8'd99);
        conv8("n100", 8'd100);
        conv8("n5", 8'd5);

        // Reset in the middle of converting 4321
        start16 = 1'b1;
        bin16   = 16'd4321;
        step();
        start16 = 1'b0;
        step(); step(); step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_busy", 32'(busy16), 32'd0);
        chk("abort_done", 32'(done16), 32'd0);
        chk("abort_bcd",  32'(bcd16),  32'd0);
        chk("abort_ovf",  32'(ovf16),  32'd0);
        chk("abort_en",   32'(en16),   32'd1);
        chk("abort_st",   32'(st16),   32'd0);
        last_exp16 = '0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (done16 || busy16) seen++;
            step();
        end
        chk("abort_quiet", 32'(seen), 32'd0);
        conv16("after_abort", 16'd4321);

        // Randomized operands
        for (int i = 0; i < 12; i++) begin
            r16 = 16'($urandom);
            conv16("rnd16", r16);
        end
        for (int i = 0; i < 12; i++) begin
            conv8("rnd8", 8'($urandom_range(0, 255)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential double-dabble binary-to-BCD converter. It sits directly downstream of the encoder counter and upstream of the per-digit seven-segment decoders. It turns the encoder's binary `value` into decimal digits, so the display reads 0–9 per digit instead of hex. One bit is processed per clock with a start/busy/done handshake. Results and status are registered and held between conversions.

## Interface
- `WIDTH`, default 16: width of the binary input.
- `DIGITS`, default 5: number of BCD digits produced. Must be ≥ 1.
- `clk`  in  1: system clock. All state changes on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: conversion request. Sampled only in IDLE.
- `bin`  in  WIDTH: unsigned binary operand. Captured on the accepting edge only.
- `busy`  out  1: high while a conversion is in progress.
- `done`  out  1: one-cycle pulse when `bcd`, `ovf` and `dig_en` update.
- `bcd`  out  4*DIGITS: result. Digit i occupies bits [4i+3:4i]; digit 0 is the ones digit.
- `ovf`  out  1: the last result exceeded 10^DIGITS − 1.
- `dig_en`  out  DIGITS: leading-zero mask for display blanking.

## Operation
- States:
  - IDLE: waiting for `start`.
  - CONV: WIDTH iterations, one bit per cycle.
- Internal registers:
  - shift register `sr` [WIDTH]
  - accumulator `acc` [4*DIGITS]
  - bit counter `cnt`, width clog2(WIDTH+1)
  - sticky overflow `ov_acc`
- Accept, IDLE with `start`=1:
  - `sr` ← `bin`, `acc` ← 0, `cnt` ← 0, `ov_acc` ← 0.
  - State → CONV, `busy` ← 1.
- Each CONV edge, in this order:
  - Each digit of `acc` that is ≥ 5 gets +3; the carry stays within its nibble.
  - The adjusted `acc` shifts left by 1, taking `sr` MSB into bit 0.
  - `sr` shifts left by 1.
  - The bit shifted out of the top of `acc` is ORed into `ov_acc`.
  - `cnt` increments.
- Final CONV edge (`cnt` == WIDTH−1):
  - `bcd` ← the final shifted `acc`.
  - `ovf` ← `ov_acc` OR this edge's shifted-out bit.
  - `dig_en` is computed from the final value.
  - `done` ← 1, `busy` ← 0, state → IDLE.
- Overflow:
  - The top carry is simply discarded, so `bcd` = `bin` mod 10^DIGITS and `ovf` = 1.
  - No saturation.
- `dig_en`:
  - Bit 0 is always 1.
  - Bit i (i ≥ 1) is 1 iff digit i or any higher digit is nonzero.
  - Does not depend on `ovf`.
- `start` while `busy`=1 is ignored: no queuing, no restart, and `bin` is not re-sampled.
- `start` held high is accepted again on every IDLE edge, i.e. continuous conversion.
- `bin` may change freely during CONV; only the value present on the accepting edge is converted.

## Timing
- Reset values: `busy`=0, `done`=0, `bcd`=0, `ovf`=0, `dig_en`=1 (bit 0 only), state IDLE, internal registers 0.
- Latency:
  - `start` accepted at edge E0.
  - `busy`=1 during cycles E0+1 … E0+WIDTH.
  - `done`=1 and new outputs appear after edge E0+WIDTH, for exactly one cycle.
- `busy` and `done` are never high in the same cycle.
- `bcd`, `ovf` and `dig_en` change only on the `done` edge and hold until the next one.
- Throughput: state is IDLE during the `done` cycle, so `start` held high is accepted at E0+WIDTH+1. The period is WIDTH+1 cycles.
- `rst`=1 on any edge, including mid-CONV:
  - Aborts the conversion and restores all reset values.
  - `done` is not pulsed; the partial result is discarded.
  - `rst` has priority over `start`.
- WIDTH=1 is legal: the only CONV edge is also the final edge.

## Test plan
- Reset, then `bin`=0 with a `start` pulse:
  - `done` exactly 16 cycles after the accepting edge.
  - `bcd`=0x00000, `ovf`=0, `dig_en`=5'b00001.
- `bin`=1234, then `bin`=65535, each with a `start` pulse:
  - `bcd`=0x01234, `dig_en`=5'b01111, `ovf`=0.
  - Then `bcd`=0x65535, `dig_en`=5'b11111.
  - `busy` high for exactly 16 cycles each time.
- `start` held high, `bin` switching 9 → 10 → 99 between accepts:
  - Successive `done` pulses every 17 cycles.
  - `bcd` = 0x00009, 0x00010, 0x00099, each held until the next `done`.
- `start` pulsed again mid-conversion with a different `bin`:
  - Ignored.
  - The result matches the first operand and `done` timing is unchanged.
- WIDTH=8, DIGITS=2, `bin`=255: `bcd`=0x55, `ovf`=1, `dig_en`=2'b11.
- WIDTH=8, DIGITS=2, `bin`=99: `bcd`=0x99, `ovf`=0.
- `rst` asserted for 1 cycle at cycle 5 of a conversion of 4321:
  - No `done` pulse.
  - Outputs return to reset values.
  - A following `start` with 4321 yields `bcd`=0x04321.
